stream_byte_packer: RTL and testbench

STREAM_BYTE_PACKER -- requirements
Module: stream_byte_packer

---
 rtl/stream_byte_packer_pkg.sv | 25 ++
 rtl/stream_byte_packer_timer.sv | 42 ++++
 rtl/stream_byte_packer.sv | 130 +++++++++++++
 tb/tb_stream_byte_packer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/stream_byte_packer_pkg.sv
// -----------------------------------------------------------------------------
// stream_byte_packer_pkg
// Shared constants, output-register state type and the byte-mask helper used
// by the stream byte packer and its idle timer.
// -----------------------------------------------------------------------------
package stream_byte_packer_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int IN_W           = 8;
    localparam int OUT_W          = 32;
    localparam int FILL_W         = 3;   // holds 0..BYTES_PER_WORD-1
    localparam int TIMER_W        = 8;   // covers TIMEOUT_CYCLES up to 255

    // Output register occupancy.
    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } out_state_t;

    // Byte-valid mask for a word holding 'fill' bytes: (1 << fill) - 1.
    function automatic logic [BYTES_PER_WORD-1:0] mask_from_fill(input logic [FILL_W-1:0] fill);
        return (BYTES_PER_WORD'(1) << fill) - BYTES_PER_WORD'(1);
    endfunction

endpackage

// File: rtl/stream_byte_packer_timer.sv
// -----------------------------------------------------------------------------
// stream_byte_packer_timer
// Idle counter for the byte packer. Counts cycles with partial data held and
// no byte accepted, saturating at TIMEOUT_CYCLES-1 so that 'expired' stays
// asserted until the partial word can actually be loaded.
//
// Ports:
//   clk      clock
//   reset    synchronous active-high reset
//   clear    restart the count (push fire, empty accumulator or flush)
//   tick     count this cycle
//   expired  count has reached TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module stream_byte_packer_timer
    import stream_byte_packer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [TIMER_W-1:0] count;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (tick && (count != LIMIT)) begin
            count <= count + TIMER_W'(1);
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/stream_byte_packer.sv
// -----------------------------------------------------------------------------
// stream_byte_packer
// Packs a stream of bytes into 32-bit words, first-accepted byte in [7:0].
// Three bytes are held in an accumulator; the fourth byte is combined with
// them straight into a single-entry output register, so a word appears one
// cycle after its last byte and the input sustains one byte per cycle.
//
// Optional feature (macro STREAM_BYTE_PACKER_TIMEOUT_EN): after
// TIMEOUT_CYCLES-1 idle cycles with partial data, the partial word is emitted
// with a mask covering only the valid lanes. Without the macro, partial bytes
// are held indefinitely and every emitted word has a full mask.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   io_push_*         byte input (valid/ready/payload)
//   io_pop_*          word output (valid/ready/payload/mask)
//   io_flush          discard accumulator and output register
//   io_fill           bytes currently held in the accumulator (0..3)
// -----------------------------------------------------------------------------
module stream_byte_packer
    import stream_byte_packer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      io_push_valid,
    output logic                      io_push_ready,
    input  logic [IN_W-1:0]           io_push_payload,
    output logic                      io_pop_valid,
    input  logic                      io_pop_ready,
    output logic [OUT_W-1:0]          io_pop_payload,
    output logic [BYTES_PER_WORD-1:0] io_pop_mask,
    input  logic                      io_flush,
    output logic [FILL_W-1:0]         io_fill
);

    localparam logic [FILL_W-1:0] LAST_LANE = FILL_W'(BYTES_PER_WORD - 1);

    out_state_t                           state, state_next;
    logic [FILL_W-1:0]                    fill;
    logic [BYTES_PER_WORD-2:0][IN_W-1:0]  acc;
    logic [OUT_W-1:0]                     pop_payload_q;
    logic [BYTES_PER_WORD-1:0]            pop_mask_q;

    logic push_fire, pop_fire, full_load, timeout_load, word_load;

    assign io_pop_valid   = (state == HOLD);
    assign io_pop_payload = pop_payload_q;
    assign io_pop_mask    = pop_mask_q;
    assign io_fill        = fill;

    // The last byte of a word needs the output register free (or draining).
    assign io_push_ready = !io_flush &&
                           !((fill == LAST_LANE) && io_pop_valid && !io_pop_ready);

    assign push_fire = io_push_valid && io_push_ready;
    assign pop_fire  = io_pop_valid && io_pop_ready;
    assign full_load = push_fire && (fill == LAST_LANE);

`ifdef STREAM_BYTE_PACKER_TIMEOUT_EN
    logic timer_expired;

    stream_byte_packer_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (io_flush || push_fire || (fill == '0)),
        .tick    (!push_fire),
        .expired (timer_expired)
    );

    // A coincident push fire wins over the timeout.
    assign timeout_load = timer_expired && !push_fire && !io_flush &&
                          (fill != '0) && (!io_pop_valid || io_pop_ready);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign timeout_load       = 1'b0;
`endif

    assign word_load = full_load || timeout_load;

    // Output register state machine.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before any branch, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            EMPTY: if (word_load)              state_next = HOLD;
            HOLD:  if (pop_fire && !word_load) state_next = EMPTY;
            default:                           state_next = EMPTY;
        endcase
        if (io_flush) state_next = EMPTY;
    end

    // Accumulator and output word. Lanes above 'fill' are kept at zero so a
    // partial word needs no extra masking of its payload.
    always_ff @(posedge clk) begin
        if (reset || io_flush) begin
            fill          <= '0;
            acc           <= '0;
            pop_payload_q <= '0;
            pop_mask_q    <= '0;
        end else if (full_load) begin
            pop_payload_q <= {io_push_payload, acc};
            pop_mask_q    <= '1;
            fill          <= '0;
            acc           <= '0;
        end else if (timeout_load) begin
            pop_payload_q <= {IN_W'(0), acc};
            pop_mask_q    <= mask_from_fill(fill);
            fill          <= '0;
            acc           <= '0;
        end else if (push_fire) begin
            acc[fill[1:0]] <= io_push_payload;
            fill           <= fill + FILL_W'(1);
        end
    end

endmodule

// File: tb/tb_stream_byte_packer.sv
// -----------------------------------------------------------------------------
// tb_stream_byte_packer
// Directed self-checking bench for stream_byte_packer. Inputs change 1 time
// unit after the rising edge and outputs are sampled at that same point.
// Define STREAM_BYTE_PACKER_TIMEOUT_EN for both bench and RTL to exercise the
// timeout build.
// -----------------------------------------------------------------------------
module tb_stream_byte_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_push_valid;
    logic        io_push_ready;
    logic [7:0]  io_push_payload;
    logic        io_pop_valid;
    logic        io_pop_ready;
    logic [31:0] io_pop_payload;
    logic [3:0]  io_pop_mask;
    logic        io_flush;
    logic [2:0]  io_fill;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    stream_byte_packer #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .io_push_valid   (io_push_valid),
        .io_push_ready   (io_push_ready),
        .io_push_payload (io_push_payload),
        .io_pop_valid    (io_pop_valid),
        .io_pop_ready    (io_pop_ready),
        .io_pop_payload  (io_pop_payload),
        .io_pop_mask     (io_pop_mask),
        .io_flush        (io_flush),
        .io_fill         (io_fill)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte for one cycle (caller ensures push_ready is high).
    task automatic push_byte(input logic [7:0] b);
        io_push_valid   = 1'b1;
        io_push_payload = b;
        step();
        io_push_valid   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int valid_seen;

        reset           = 1'b1;
        io_push_valid   = 1'b0;
        io_push_payload = 8'h00;
        io_pop_ready    = 1'b0;
        io_flush        = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        check("rst_pop_valid",   32'(io_pop_valid),  32'd0);
        check("rst_pop_payload", io_pop_payload,     32'h0);
        check("rst_pop_mask",    32'(io_pop_mask),   32'h0);
        check("rst_fill",        32'(io_fill),       32'd0);
        check("rst_push_ready",  32'(io_push_ready), 32'd1);

        // Four bytes back to back, downstream ready
        io_pop_ready = 1'b1;
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        check("w1_fill3",        32'(io_fill),       32'd3);
        check("w1_ready_fill3",  32'(io_push_ready), 32'd1);
        push_byte(8'h44);
        check("w1_pop_valid",    32'(io_pop_valid),  32'd1);
        check("w1_payload",      io_pop_payload,     32'h44332211);
        check("w1_mask",         32'(io_pop_mask),   32'hF);
        check("w1_fill0",        32'(io_fill),       32'd0);
        step();
        check("w1_popped",       32'(io_pop_valid),  32'd0);

        // Eight bytes with downstream stalled
        io_pop_ready = 1'b0;
        for (int b = 1; b <= 7; b++) push_byte(8'(b));
        check("bp_fill3",        32'(io_fill),       32'd3);
        check("bp_hold_valid",   32'(io_pop_valid),  32'd1);
        io_push_valid   = 1'b1;
        io_push_payload = 8'h08;
        check("bp_ready_low",    32'(io_push_ready), 32'd0);
        step();
        check("bp_ready_still",  32'(io_push_ready), 32'd0);
        check("bp_fill_held",    32'(io_fill),       32'd3);
        check("bp_word1_stable", io_pop_payload,     32'h04030201);
        check("bp_mask1_stable", 32'(io_pop_mask),   32'hF);
        io_pop_ready = 1'b1;
        #1;
        check("bp_ready_release", 32'(io_push_ready), 32'd1);
        step();
        io_push_valid = 1'b0;
        check("bp_word2_valid",  32'(io_pop_valid),  32'd1);
        check("bp_word2",        io_pop_payload,     32'h08070605);
        check("bp_fill_after",   32'(io_fill),       32'd0);
        step();
        check("bp_drained",      32'(io_pop_valid),  32'd0);

        // Flush with a word in HOLD and two bytes pending
        io_pop_ready = 1'b0;
        for (int b = 0; b < 4; b++) push_byte(8'h10 + 8'(b));
        push_byte(8'h20);
        push_byte(8'h21);
        check("fl_pre_fill",     32'(io_fill),       32'd2);
        check("fl_pre_valid",    32'(io_pop_valid),  32'd1);
        io_flush      = 1'b1;
        io_pop_ready  = 1'b1;
        io_push_valid = 1'b1;
        io_push_payload = 8'hEE;
        #1;
        check("fl_ready_low",    32'(io_push_ready), 32'd0);
        step();
        io_flush      = 1'b0;
        io_push_valid = 1'b0;
        io_pop_ready  = 1'b0;
        check("fl_fill",         32'(io_fill),       32'd0);
        check("fl_valid",        32'(io_pop_valid),  32'd0);
        check("fl_payload",      io_pop_payload,     32'h0);
        check("fl_mask",         32'(io_pop_mask),   32'h0);
        for (int b = 0; b < 4; b++) push_byte(8'hA0 + 8'(b));
        check("fl_next_valid",   32'(io_pop_valid),  32'd1);
        check("fl_next_word",    io_pop_payload,     32'hA3A2A1A0);
        io_pop_ready = 1'b1;
        step();
        check("fl_drained",      32'(io_pop_valid),  32'd0);

        // Two bytes followed by idle cycles
        push_byte(8'h5A);
        push_byte(8'h6B);
`ifdef STREAM_BYTE_PACKER_TIMEOUT_EN
        io_pop_ready = 1'b0;
        step();
        step();
        step();
        check("to_not_yet",      32'(io_pop_valid),  32'd0);
        check("to_fill_held",    32'(io_fill),       32'd2);
        step();
        check("to_valid",        32'(io_pop_valid),  32'd1);
        check("to_payload",      io_pop_payload,     32'h00006B5A);
        check("to_mask",         32'(io_pop_mask),   32'h3);
        check("to_fill0",        32'(io_fill),       32'd0);
        io_pop_ready = 1'b1;
        step();
        check("to_drained",      32'(io_pop_valid),  32'd0);
`else
        valid_seen = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (io_pop_valid) valid_seen++;
        end
        check("idle_no_word",    32'(valid_seen),    32'd0);
        check("idle_fill2",      32'(io_fill),       32'd2);
        push_byte(8'h7C);
        push_byte(8'h8D);
        check("idle_complete",   io_pop_payload,     32'h8D7C6B5A);
        check("idle_full_mask",  32'(io_pop_mask),   32'hF);
        step();
`endif

        // Reset mid-word with a word in HOLD and three bytes pending
        io_pop_ready = 1'b0;
        for (int b = 0; b < 4; b++) push_byte(8'hC0 + 8'(b));
        for (int b = 0; b < 3; b++) push_byte(8'hD0 + 8'(b));
        check("rm_pre_fill",     32'(io_fill),       32'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rm_valid",        32'(io_pop_valid),  32'd0);
        check("rm_payload",      io_pop_payload,     32'h0);
        check("rm_mask",         32'(io_pop_mask),   32'h0);
        check("rm_fill",         32'(io_fill),       32'd0);
        check("rm_push_ready",   32'(io_push_ready), 32'd1);
        io_pop_ready = 1'b1;
        valid_seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (io_pop_valid) valid_seen++;
        end
        check("rm_no_word",      32'(valid_seen),    32'd0);
        for (int b = 0; b < 4; b++) push_byte(8'hE0 + 8'(b));
        check("rm_after_word",   io_pop_payload,     32'hE3E2E1E0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
